// File: rtl/alu_pkg.sv
// Shared definitions for the operand loader: FSM state encoding, Phase LED codes
// and the default opcode width.
package alu_pkg;

    localparam int OPW_DEFAULT = 3;

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_GO   = 3'd3,
        S_DONE = 3'd4
    } stateT;

    localparam logic [1:0] PH_A    = 2'b00;
    localparam logic [1:0] PH_B    = 2'b01;
    localparam logic [1:0] PH_OP   = 2'b10;
    localparam logic [1:0] PH_EXEC = 2'b11;

    // S_GO and S_DONE share the same LED code
    function automatic logic [1:0] phaseOf(stateT s);
        logic [1:0] ph;
        ph = PH_EXEC;
        case (s)
            S_A:     ph = PH_A;
            S_B:     ph = PH_B;
            S_OP:    ph = PH_OP;
            default: ph = PH_EXEC;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser for the raw pushbutton, optionally followed by a stability
// debouncer when OPERAND_LOADER_DEBOUNCE_EN is defined.
module btn_debounce #(
    parameter int DB_CYCLES = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic In,
    output logic Level
);

    logic [1:0] syncQ;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) syncQ <= '0;
        else      syncQ <= {syncQ[0], In};
    end

`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // Level flips on the DB_CYCLES-th consecutive cycle of disagreement
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt   <= '0;
            Level <= 1'b0;
        end else if (syncQ[1] == Level) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt   <= '0;
            Level <= ~Level;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
`else
    // DB_CYCLES is always >= 1, so this is a plain pass-through of the synchroniser
    assign Level = syncQ[1] & (DB_CYCLES >= 1);
`endif

endmodule

// File: rtl/operand_loader.sv
// Loads operands A, B and opcode Op from the switches on successive button presses,
// then strobes Go for one cycle. Debounce enabled by OPERAND_LOADER_DEBOUNCE_EN.
module operand_loader
    import alu_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int OPW       = OPW_DEFAULT,
    parameter int DB_CYCLES = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Btn,
    input  logic [WIDTH-1:0] Sw,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [OPW-1:0]   Op,
    output logic             Go,
    output logic [1:0]       Phase
);

    logic  db;
    logic  dbPrev;
    logic  press;
    stateT state;
    stateT stateNext;

    btn_debounce #(
        .DB_CYCLES(DB_CYCLES)
    ) uDebounce (
        .Clk  (Clk),
        .Rst  (Rst),
        .In   (Btn),
        .Level(db)
    );

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) dbPrev <= 1'b0;
        else      dbPrev <= db;
    end

    assign press = db & ~dbPrev;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) state <= S_A;
        else      state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_A:     if (press) stateNext = S_B;
            S_B:     if (press) stateNext = S_OP;
            S_OP:    if (press) stateNext = S_GO;
            S_GO:    stateNext = S_DONE;
            S_DONE:  if (press) stateNext = S_B;
            default: stateNext = S_A;
        endcase
    end

    always_comb begin
        Go    = (state == S_GO);
        Phase = phaseOf(state);
    end

    // Sw is sampled only on the edge that ends a press cycle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            A  <= '0;
            B  <= '0;
            Op <= '0;
        end else if (press) begin
            case (state)
                S_A, S_DONE: A  <= Sw;
                S_B:         B  <= Sw;
                S_OP:        Op <= Sw[OPW-1:0];
                default:     ;
            endcase
        end
    end

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader; works with or without OPERAND_LOADER_DEBOUNCE_EN.
module tb_operand_loader;

    localparam int DB = 4;
`ifdef OPERAND_LOADER_DEBOUNCE_EN
    localparam int LAT = 2 + DB;
`else
    localparam int LAT = 2;
`endif

    logic       Clk;
    logic       Rst;
    logic       Btn;
    logic [3:0] Sw;
    logic [3:0] A;
    logic [3:0] B;
    logic [2:0] Op;
    logic       Go;
    logic [1:0] Phase;

    int vectors     = 0;
    int miscompares = 0;
    int goCnt       = 0;

    operand_loader #(
        .WIDTH    (4),
        .OPW      (3),
        .DB_CYCLES(DB)
    ) dut (
        .Clk  (Clk),
        .Rst  (Rst),
        .Btn  (Btn),
        .Sw   (Sw),
        .A    (A),
        .B    (B),
        .Op   (Op),
        .Go   (Go),
        .Phase(Phase)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(negedge Clk) if (Go === 1'b1) goCnt++;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Press with Sw valid up to the capture edge, then scramble Sw while still held
    task automatic doPress(input logic [3:0] sw);
        Sw  = sw;
        Btn = 1'b1;
        repeat (LAT + 1) tick();
        Sw = ~sw;
        repeat (3) tick();
        Btn = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    task automatic doReset();
        Btn = 1'b0;
        Rst = 1'b0;
        repeat (2) tick();
        Rst = 1'b1;
        tick();
    endtask

    initial begin
        Rst = 1'b0;
        Btn = 1'b0;
        Sw  = 4'h0;
        #2;
        check("rst_A", A, 0);
        check("rst_B", B, 0);
        check("rst_Op", Op, 0);
        check("rst_Go", Go, 0);
        check("rst_Phase", Phase, 2'b00);
        repeat (2) tick();
        Rst = 1'b1;
        tick();

        // First press with exact capture-edge latency
        Sw  = 4'h5;
        Btn = 1'b1;
        repeat (LAT) tick();
        check("lat_A_before", A, 0);
        check("lat_Phase_before", Phase, 2'b00);
        tick();
        check("lat_A_at", A, 4'h5);
        check("lat_Phase_at", Phase, 2'b01);
        Sw = 4'hA;
        repeat (3) tick();
        Btn = 1'b0;
        repeat (LAT + 2) tick();
        check("A_hold", A, 4'h5);

        doPress(4'h3);
        check("B_cap", B, 4'h3);
        check("Phase_OP", Phase, 2'b10);

        // Opcode capture enters S_GO: Go for exactly one cycle
        Sw  = 4'h2;
        Btn = 1'b1;
        repeat (LAT + 1) tick();
        check("Op_cap", Op, 3'h2);
        check("Go_high", Go, 1);
        check("Phase_GO", Phase, 2'b11);
        Sw = 4'h7;
        tick();
        check("Go_low", Go, 0);
        check("Phase_DONE", Phase, 2'b11);
        repeat (3) tick();
        Btn = 1'b0;
        repeat (LAT + 2) tick();
        check("Go_count", goCnt, 1);
        check("A_final", A, 4'h5);
        check("B_final", B, 4'h3);
        check("Op_final", Op, 3'h2);

        // Press in S_DONE reloads A only
        doPress(4'hC);
        check("done_A", A, 4'hC);
        check("done_Phase", Phase, 2'b01);
        check("done_B", B, 4'h3);
        check("done_Op", Op, 3'h2);
        check("done_Go_count", goCnt, 1);

`ifdef OPERAND_LOADER_DEBOUNCE_EN
        // Short glitch must be rejected by the debouncer
        doReset();
        Sw  = 4'hE;
        Btn = 1'b1;
        repeat (3) tick();
        Btn = 1'b0;
        repeat (3) tick();
        Sw  = 4'h9;
        Btn = 1'b1;
        repeat (10) tick();
        Btn = 1'b0;
        repeat (LAT + 2) tick();
        check("glitch_A", A, 4'h9);
        check("glitch_Phase", Phase, 2'b01);
`endif

        // Long hold gives a single capture
        doReset();
        Sw  = 4'h6;
        Btn = 1'b1;
        repeat (100) tick();
        Btn = 1'b0;
        repeat (LAT + 2) tick();
        check("hold_A", A, 4'h6);
        check("hold_B", B, 0);
        check("hold_Phase", Phase, 2'b01);

        // Asynchronous reset from S_OP, checked between clock edges
        doReset();
        doPress(4'h7);
        doPress(4'h1);
        check("pre_rst_Phase", Phase, 2'b10);
        check("pre_rst_B", B, 4'h1);
        #2;
        Rst = 1'b0;
        #1;
        check("arst_A", A, 0);
        check("arst_B", B, 0);
        check("arst_Op", Op, 0);
        check("arst_Go", Go, 0);
        check("arst_Phase", Phase, 2'b00);
        tick();
        Rst = 1'b1;
        tick();
        doPress(4'h4);
        check("post_rst_A", A, 4'h4);
        check("post_rst_Phase", Phase, 2'b01);

        // Button held through reset release presses only after normal latency
        Sw  = 4'h8;
        Btn = 1'b1;
        Rst = 1'b0;
        repeat (2) tick();
        Rst = 1'b1;
        repeat (LAT) tick();
        check("rel_A_before", A, 0);
        tick();
        check("rel_A_at", A, 4'h8);
        check("rel_Phase", Phase, 2'b01);
        Btn = 1'b0;
        repeat (LAT + 2) tick();
        check("end_Go_count", goCnt, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 4: operand width in bits.
REQ-002 SHALL have parameter OPW, default 3: opcode width in bits; OPW <= WIDTH.
REQ-003 SHALL have parameter DB_CYCLES, default 4: debounce stability count in cycles, >= 1.
REQ-004 SHALL have port Clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-005 SHALL have port Rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port Btn, input, 1 bit: raw, asynchronous load pushbutton.
REQ-007 SHALL have port Sw, input, WIDTH bits: data switches.
REQ-008 SHALL have port A, output, WIDTH bits: registered operand A.
REQ-009 SHALL have port B, output, WIDTH bits: registered operand B.
REQ-010 SHALL have port Op, output, OPW bits: registered opcode.
REQ-011 SHALL have port Go, output, 1 bit: one-cycle execute strobe that drives the ALU result register enable.
REQ-012 SHALL have port Phase, output, 2 bits: encoded current state for LED display.

Function
REQ-013 SHALL synchronise Btn through two flip-flops to produce BtnS; Sw is sampled unsynchronised.
REQ-014 SHALL define a press as the single cycle in which the debounced level Db is 1 and its previous-cycle value is 0.
REQ-015 SHALL register exactly one press per Btn assertion, regardless of how long Btn is held.
REQ-016 SHALL implement states S_A, S_B, S_OP, S_GO, S_DONE, with Phase encoded 00, 01, 10, 11, 11 respectively.
REQ-017 SHALL, on a press in S_A: A <= Sw; next state S_B.
REQ-018 SHALL, on a press in S_B: B <= Sw; next state S_OP.
REQ-019 SHALL, on a press in S_OP: Op <= Sw[OPW-1:0]; next state S_GO.
REQ-020 SHALL, in S_GO: assert Go=1 for exactly that one cycle; next state S_DONE unconditionally; any press occurring in S_GO is ignored.
REQ-021 SHALL, on a press in S_DONE: A <= Sw; next state S_B. S_A is therefore reachable only through reset.
REQ-022 SHALL assert Go=0 in every state other than S_GO.
REQ-023 SHALL hold A, B and Op stable except at their own capture edge; Sw changes at any other time have no effect.
REQ-024 SHALL sample Sw at the capture edge itself, i.e. the edge ending the press cycle.

Reset
REQ-025 SHALL, while Rst=0, asynchronously force: state S_A, A=0, B=0, Op=0, Go=0, Phase=00, both synchroniser flops 0, Db=0, previous Db=0, debounce counter 0.
REQ-026 SHALL, on reset asserted mid-sequence (for example in S_OP), discard all partial captures.
REQ-027 SHALL NOT generate a press from a Btn held high through reset release until Db has risen from 0 under the normal rules.

Configuration
REQ-028 SHALL use macro OPERAND_LOADER_DEBOUNCE_EN.
REQ-029 SHALL, with the macro defined: count consecutive cycles in which BtnS != Db; Db toggles when the count reaches DB_CYCLES; the count clears whenever BtnS == Db.
REQ-030 SHALL, with the macro defined: for Btn rising before edge k and held high, capture at edge k+2+DB_CYCLES.
REQ-031 SHALL, without the macro: set Db = BtnS with no counter logic and ignore DB_CYCLES, giving capture at edge k+2.

Structure
REQ-032 SHALL place the state enum/encoding, Phase encodings and default OPW in shared package alu_pkg.
REQ-033 SHALL implement the synchroniser and debounce logic in sub-module btn_debounce (ports Clk, Rst, In, Level), which contains the OPERAND_LOADER_DEBOUNCE_EN conditional.

Verification
REQ-034 SHALL verify, macro on, DB_CYCLES=4: three clean presses with Sw=4'h5, 4'h3, 4'h2 -> A=5, B=3, Op=2; Go=1 for exactly one cycle; Phase ends at 11.
REQ-035 SHALL verify, macro on: Btn glitches high for 3 cycles, then high for 10 cycles with Sw=4'h9 -> only one capture, A=9, Phase=01.
REQ-036 SHALL verify: Btn held high for 100 cycles in S_A -> exactly one capture, state S_B.
REQ-037 SHALL verify: Rst=0 pulsed while in S_OP with A=7, B=1 -> A=B=Op=0, Go=0, Phase=00, asynchronously, without waiting for a clock edge.
REQ-038 SHALL verify: press in S_DONE with Sw=4'hC -> A=C, Phase=01, B and Op unchanged, Go stays 0.
REQ-039 SHALL verify, macro off: Btn rises before edge k -> A captured at edge k+2; measured capture-edge latency equals k+6 with the macro on.
